// File: rtl/dmem_ctrl.sv
// dmem_ctrl: memory-stage access controller between the execute stage and a
// multi-cycle, stall-capable data memory. Each load/store is sequenced as
// issue -> wait-for-done -> complete while the pipeline is held with `stall`.
// Load data is registered for writeback. Illegal accesses and timeouts raise `err`.
// A HALT request produces the single memory-dump pulse.
//
// Optional build macro: DMEM_ALIGN_CHECK_EN
//   defined   - an odd byte address is rejected with err and no memory access
//   undefined - addr[0] is forced to 0 on mem_addr and the access proceeds
module dmem_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        halt,
    input  logic [15:0] addr,
    input  logic [15:0] writedata,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    input  logic        mem_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_createdump,
    output logic        stall,
    output logic [15:0] readData,
    output logic        rd_valid,
    output logic        err,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_DUMP   = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state_r;
    logic [7:0]  wait_cnt_r;
    logic        is_read_r;
    logic        access_req_s;
    logic        misalign_s;

    // Decode the incoming request and the optional alignment rule.
    always_comb begin
        access_req_s = req_valid & (MemRead | MemWrite);
`ifdef DMEM_ALIGN_CHECK_EN
        misalign_s   = addr[0];
`else
        misalign_s   = 1'b0;
`endif
    end

    // Hold the pipeline from the very first cycle of a memory or halt request.
    always_comb begin
        if ((state_r == S_ISSUE) || (state_r == S_WAIT) || (state_r == S_DUMP)) begin
            stall = 1'b1;
        end else if (state_r == S_IDLE) begin
            stall = req_valid & (MemRead | MemWrite | halt);
        end else begin
            stall = 1'b0;
        end
    end

    // Access sequencer: state, wait counter, latches and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= S_IDLE;
            wait_cnt_r     <= 8'd0;
            is_read_r      <= 1'b0;
            mem_addr       <= 16'h0000;
            mem_data_in    <= 16'h0000;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_createdump <= 1'b0;
            readData       <= 16'h0000;
            rd_valid       <= 1'b0;
            err            <= 1'b0;
            halted         <= 1'b0;
        end else begin
            // single-cycle outputs default low; a state raises them as needed
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_createdump <= 1'b0;
            rd_valid       <= 1'b0;
            err            <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_valid && halt) begin
                        state_r        <= S_DUMP;
                        mem_createdump <= 1'b1;
                    end else if (req_valid && MemRead && MemWrite) begin
                        state_r <= S_DONE;
                        err     <= 1'b1;
                    end else if (access_req_s && misalign_s) begin
                        state_r <= S_DONE;
                        err     <= 1'b1;
                    end else if (access_req_s) begin
                        // addr[0] is dropped: only aligned addresses reach memory
                        state_r     <= S_ISSUE;
                        mem_addr    <= {addr[15:1], 1'b0};
                        mem_data_in <= writedata;
                        is_read_r   <= MemRead;
                        mem_rd      <= MemRead;
                        mem_wr      <= MemWrite;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (mem_stall) begin
                        // bank busy: present the same strobe again next cycle
                        mem_rd <= is_read_r;
                        mem_wr <= ~is_read_r;
                    end else begin
                        state_r    <= S_WAIT;
                        wait_cnt_r <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        if (is_read_r) begin
                            readData <= mem_data_out;
                        end else begin
                            readData <= readData;
                        end
                        rd_valid <= 1'b1;
                        state_r  <= S_DONE;
                    end else if ((wait_cnt_r + 8'd1) == WAIT_LIMIT) begin
                        err      <= 1'b1;
                        readData <= 16'hFFFF;
                        state_r  <= S_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                S_DONE: begin
                    // the still-present request is the one just completed
                    state_r <= S_IDLE;
                end
                S_DUMP: begin
                    state_r <= S_HALTED;
                    halted  <= 1'b1;
                end
                S_HALTED: begin
                    state_r <= S_HALTED;
                    halted  <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. A transaction-level reference model
// predicts latency, strobe count, load data and status of each access.
// The memory responder drives mem_stall and mem_done per transaction.
module tb_dmem_ctrl;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, MemRead, MemWrite, halt;
    logic [15:0] addr, writedata, mem_data_out;
    logic        mem_done, mem_stall;
    logic [15:0] mem_addr, mem_data_in, readData;
    logic        mem_rd, mem_wr, mem_createdump, stall, rd_valid, err, halted;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mem_model [0:255];
    logic [15:0] exp_rdata;

    dmem_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .halt(halt), .addr(addr), .writedata(writedata),
        .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_createdump(mem_createdump), .stall(stall),
        .readData(readData), .rd_valid(rd_valid), .err(err), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access. nstall = cycles the memory rejects the issue,
    // done_at = WAIT cycle index on which mem_done is returned (>= MAXW: never).
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] wd, input int nstall, input int done_at);
        int          stall_cnt, strobe_cnt, wait_idx, bad_addr, bad_dir, exp_stall;
        logic        fin, got_rv, got_err, illegal, success;
        logic [15:0] ea;
        stall_cnt = 0; strobe_cnt = 0; wait_idx = 0; bad_addr = 0; bad_dir = 0;
        fin = 1'b0; got_rv = 1'b0; got_err = 1'b0;
        ea      = {a[15:1], 1'b0};
        illegal = rd & wr;
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[0]) illegal = 1'b1;
`endif
        success = !illegal && (done_at < MAXW);

        @(negedge clk);
        req_valid = 1'b1; MemRead = rd; MemWrite = wr; halt = 1'b0;
        addr = a; writedata = wd; mem_stall = 1'b0; mem_done = 1'b0;
        #1;
        if (stall) stall_cnt++;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            mem_done     = 1'b0;
            mem_stall    = 1'b0;
            mem_data_out = 16'($urandom);
            if (rd_valid || err) begin
                fin = 1'b1; got_rv = rd_valid; got_err = err;
            end else if (mem_rd || mem_wr) begin
                strobe_cnt++;
                if (mem_addr !== ea || (wr && mem_data_in !== wd)) bad_addr++;
                if (mem_rd !== rd || mem_wr !== wr) bad_dir++;
                mem_stall = (strobe_cnt <= nstall);
            end else if (strobe_cnt > 0) begin
                if (wait_idx == done_at) begin
                    mem_done = 1'b1;
                    if (rd) mem_data_out = mem_model[ea[8:1]];
                end
                wait_idx++;
            end
            #1;
            if (stall) stall_cnt++;
        end
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        mem_done = 1'b0; mem_stall = 1'b0;

        if (!fin) begin
            check_eq("completion_seen", 32'(fin), 32'd1);
        end else begin
            if (illegal) begin
                exp_stall = 1;
            end else if (success) begin
                exp_stall = 1 + (nstall + 1) + (done_at + 1);
            end else begin
                exp_stall = 1 + (nstall + 1) + MAXW;
            end
            if (!illegal && !success) exp_rdata = 16'hFFFF;
            else if (success && rd) exp_rdata = mem_model[ea[8:1]];
            if (success && wr) mem_model[ea[8:1]] = wd;
            check_eq("rd_valid", 32'(got_rv), 32'(success));
            check_eq("err", 32'(got_err), 32'(!success));
            check_eq("readData", 32'(readData), 32'(exp_rdata));
            check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
            check_eq("strobe_cycles", 32'(strobe_cnt), illegal ? 32'd0 : 32'(nstall + 1));
            check_eq("strobe_addr_data", 32'(bad_addr), 32'd0);
            check_eq("strobe_dir", 32'(bad_dir), 32'd0);
        end
        @(negedge clk);
        check_eq("status_single_cycle", {30'd0, rd_valid, err}, 32'd0);
        check_eq("idle_no_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind, ns, da;
        logic [15:0] ra;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 257) ^ 16'h5A5A;
        mem_model[8'h20] = 16'hBEEF;
        exp_rdata = 16'h0000;
        rst = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; halt = 1'b0;
        addr = 16'h0000; writedata = 16'h0000; mem_data_out = 16'h0000;
        mem_done = 1'b0; mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_strobes", {28'd0, mem_rd, mem_wr, mem_createdump, halted}, 32'd0);
        check_eq("rst_status", {30'd0, rd_valid, err}, 32'd0);
        check_eq("rst_readData", 32'(readData), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // directed cases
        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 0);   // BEEF load, minimum latency
        do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 2, 1);   // store with two bank stalls
        do_access(1'b1, 1'b0, 16'h0060, 16'h0000, 0, 99);  // timeout
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 2);   // accepted after timeout, reads 1234
        do_access(1'b1, 1'b0, 16'h0041, 16'h0000, 0, 0);   // odd address
        do_access(1'b1, 1'b1, 16'h0020, 16'h5555, 0, 0);   // both strobes requested
        do_access(1'b1, 1'b0, 16'h0080, 16'h0000, 1, MAXW - 1); // done on last WAIT cycle

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 7));
            ns   = int'($urandom_range(0, 3));
            ra   = 16'($urandom_range(0, 511));
            if (kind == 0) begin
                do_access(1'b1, 1'b1, ra, 16'($urandom), ns, 0);
            end else if (kind <= 4) begin
                da = int'($urandom_range(0, MAXW + 1));
                do_access(1'b1, 1'b0, ra, 16'h0000, ns, da);
            end else begin
                da = int'($urandom_range(0, MAXW - 1));
                do_access(1'b0, 1'b1, ra, 16'($urandom), ns, da);
            end
        end

        // reset in the middle of WAIT, then a late mem_done
        @(negedge clk);
        req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 16'h0022;
        @(negedge clk);   // ISSUE
        @(negedge clk);   // WAIT
        @(negedge clk);   // WAIT
        rst = 1'b0; req_valid = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b1; mem_done = 1'b1; mem_data_out = 16'hDEAD;
        check_eq("midrst_readData", 32'(readData), 32'd0);
        check_eq("midrst_outputs", {26'd0, mem_rd, mem_wr, mem_createdump, halted, rd_valid, err}, 32'd0);
        check_eq("midrst_mem_data_in", 32'(mem_data_in), 32'd0);
        #1;
        check_eq("midrst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_done = 1'b0;
        check_eq("late_done_ignored", {30'd0, rd_valid, err}, 32'd0);
        check_eq("late_done_readData", 32'(readData), 32'd0);
        exp_rdata = 16'h0000;
        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 1);

        // halt together with a load
        @(negedge clk);
        req_valid = 1'b1; halt = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        check_eq("halt_req_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check_eq("dump_pulse", 32'(mem_createdump), 32'd1);
        check_eq("dump_no_rd", 32'(mem_rd), 32'd0);
        check_eq("dump_not_halted", 32'(halted), 32'd0);
        #1;
        check_eq("dump_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check_eq("dump_single", 32'(mem_createdump), 32'd0);
        check_eq("halted_set", 32'(halted), 32'd1);
        #1;
        check_eq("halted_no_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("halted_no_access", {29'd0, mem_rd, mem_wr, rd_valid}, 32'd0);
            check_eq("halted_hold", {30'd0, halted, mem_createdump}, 32'd2);
            req_valid = 1'b1; MemRead = 1'b1; halt = 1'(i % 2);
            addr = 16'($urandom_range(0, 511));
            #1;
            check_eq("halted_req_stall", 32'(stall), 32'd0);
        end
        req_valid = 1'b0; MemRead = 1'b0; halt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
